// File: rtl/ni_packetizer.sv
// Network-interface injection stage: turns a (dst, len) command plus a payload
// word stream into head/body/tail flits on a req/ack router channel.
module ni_packetizer #(
    parameter int SRC_ID = 4,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [33:0]      out_flit,
    output logic             out_req,
    input  logic             in_ack,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    localparam logic [3:0] SRC = SRC_ID[3:0];

    state_t             state_reg, state_next;
    logic [33:0]        flit_reg, flit_next;
    logic               req_reg, req_next;
    logic [LEN_W-1:0]   rem_reg, rem_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]         len8;
    logic               xfer;

    // The head flit carries an 8-bit length field regardless of LEN_W.
    generate
        if (LEN_W >= 8) begin : g_len_trunc
            assign len8 = cmd_len[7:0];
        end else begin : g_len_ext
            assign len8 = {{(8 - LEN_W){1'b0}}, cmd_len};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        flit_next  = flit_reg;
        req_next   = req_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        xfer       = req_reg && in_ack;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    flit_next  = {1'b1, (cmd_len == '0), cmd_dst, SRC, len8, 16'h0000};
                    req_next   = 1'b1;
                    rem_next   = cmd_len;
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    if (rem_reg == '0) begin
                        req_next   = 1'b0;
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = IDLE;
                    end else begin
                        // Head drains this edge, so the first word may load in its place.
                        state_next = BODY;
                        data_ready = 1'b1;
                        if (data_valid) begin
                            flit_next = {1'b0, (rem_reg == LEN_W'(1)), data_in};
                            req_next  = 1'b1;
                            rem_next  = rem_reg - LEN_W'(1);
                        end else begin
                            req_next = 1'b0;
                        end
                    end
                end
            end
            BODY: begin
                data_ready = (!req_reg || in_ack) && (rem_reg != '0);
                if (data_ready && data_valid) begin
                    flit_next = {1'b0, (rem_reg == LEN_W'(1)), data_in};
                    req_next  = 1'b1;
                    rem_next  = rem_reg - LEN_W'(1);
                end else if (xfer) begin
                    req_next = 1'b0;
                    if (flit_reg[32]) begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            flit_reg  <= '0;
            req_reg   <= 1'b0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            flit_reg  <= flit_next;
            req_reg   <= req_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign out_flit = flit_reg;
    assign out_req  = req_reg;
    assign pkt_cnt  = cnt_reg;
    assign busy     = (state_reg != IDLE);

endmodule
